reset_sequencer: RTL
====================

// Module: reset_sequencer
// PURPOSE
//  Board-level reset controller for the 65C02 system. Fed by the external button and the PLL.
//  Releases domain resets in a fixed order after power-up or PLL lock: peripherals, then
//  memory/ROM loader, then CPU. Re-runs the sequence on button press, software request or PLL
//  loss, and latches the cause. All reset outputs are active-high, matching system consumers.
// PARAMETERS
//  DEBOUNCE_CYCLES  270000  clocks btn must be stable before a press/release is accepted (10ms@27MHz)
//  PERIPH_CYCLES    16      clocks in REL_PERIPH before periph_reset deasserts
//  MEM_CYCLES       16      clocks in REL_MEM before mem_reset deasserts
//  CPU_CYCLES       64      clocks in REL_CPU before cpu_reset deasserts (>=2 CPU phi2 cycles)
//  CNT_W            20      width of shared delay/debounce counters; must hold the largest count
// PORTS
//  clk           in   1  system clock
//  reset_n       in   1  asynchronous active-low reset
//  pll_lock      in   1  PLL locked, asynchronous; 2-FF synchronised internally
//  btn_n         in   1  user reset button, active-low, asynchronous; 2-FF sync + debounce
//  soft_rst_req  in   1  one-clk synchronous pulse from the CPU-visible control register
//  periph_reset  out  1  peripheral domain reset, active-high
//  mem_reset     out  1  memory/ROM-loader reset, active-high
//  cpu_reset     out  1  CPU reset, active-high
//  seq_done      out  1  high in RUN only (all resets released)
//  rst_cause     out  2  last cause: 00 POR, 01 button, 10 soft, 11 PLL loss
// BEHAVIOUR
//  reset_n low, asynchronous effect:
//   - state=POR; counters cleared.
//   - periph/mem/cpu_reset=1, seq_done=0, rst_cause=00.
//   - Deassertion of reset_n acts on the next clk edge.
//  All outputs are registered. Resets assert asynchronously only via reset_n; all other
//  assert/release is synchronous.
//  lock_s: pll_lock after 2 FFs (2-clk latency).
//  btn_pressed: btn_n after 2 FFs, then a debouncer.
//   - Changes only after DEBOUNCE_CYCLES consecutive equal samples.
//   - Any toggle reloads the counter.
//  States and transitions:
//   POR        : 1 clk, all resets asserted -> WAIT_LOCK.
//   WAIT_LOCK  : all asserted; leave when lock_s=1 && !btn_pressed -> REL_PERIPH, cnt=0.
//   REL_PERIPH : cnt++.
//                At cnt==PERIPH_CYCLES-1: periph_reset<=0 -> REL_MEM, cnt=0.
//   REL_MEM    : cnt++.
//                At cnt==MEM_CYCLES-1: mem_reset<=0 -> REL_CPU, cnt=0.
//   REL_CPU    : cnt++.
//                At cnt==CPU_CYCLES-1: cpu_reset<=0, seq_done<=1 -> RUN.
//   RUN        : hold. Trigger -> ASSERT.
//                Triggers: !lock_s, btn_pressed rising, soft_rst_req.
//   ASSERT     : 1 clk. All three resets <=1, seq_done<=0, rst_cause latched -> WAIT_LOCK.
//  Delay counts:
//   - Each domain is released exactly N clks after entering its REL_* state.
//   - No release occurs before the preceding domain is released.
//  Cause priority when triggers coincide: PLL loss(11) > button(01) > soft(10).
//  Triggers outside RUN:
//   - !lock_s or btn_pressed in any REL_* state -> ASSERT.
//   - Already-released domains are re-asserted and the cause is latched.
//   - soft_rst_req is ignored outside RUN.
//  Button held: sequence stays in WAIT_LOCK until debounced release. No auto-repeat.
//  Counter saturation: none needed; every count is bounded by its state exit.
// TESTING (sim params: DEBOUNCE=4, PERIPH=2, MEM=3, CPU=4)
//  1 Release reset_n with pll_lock=1, btn_n=1:
//     - periph_reset falls ~2 clks after REL_PERIPH entry, mem_reset 3 clks later, cpu_reset 4 later.
//     - seq_done=1 with cpu_reset fall; rst_cause=00.
//  2 pll_lock=0 for 50 clks after reset, then 1:
//     - all resets stay 1 throughout.
//     - Sequence starts 2 clks after lock (sync latency).
//  3 In RUN, pulse soft_rst_req 1 clk:
//     - all resets=1 within 2 clks, rst_cause=10, full sequence re-runs.
//  4 In RUN, btn_n glitch of 3 clks: no effect.
//     - btn_n low 10 clks: reset after debounce, rst_cause=01.
//     - Held in WAIT_LOCK until btn_n high >=4 clks.
//  5 During REL_MEM, drop pll_lock:
//     - periph_reset re-asserts, rst_cause=11.
//     - soft_rst_req in same window is ignored.
//  6 Assert reset_n mid-REL_CPU: all resets=1 asynchronously, rst_cause=00.
//     - Release reset_n: clean POR sequence.

Source files
------------

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//   Board-level reset controller for the 65C02 system. After power-up, PLL
//   lock, a button press, a software request or a PLL loss, it releases the
//   domain resets in a fixed order: peripherals, then memory/ROM loader, then
//   CPU. It also records why the last reset sequence was started.
//
// Ports
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset
//   pll_lock      in   PLL locked (asynchronous, 2-FF synchronised)
//   btn_n         in   user reset button, active-low (asynchronous, 2-FF + debounce)
//   soft_rst_req  in   one-clock synchronous software reset request
//   periph_reset  out  peripheral domain reset, active-high
//   mem_reset     out  memory/ROM-loader reset, active-high
//   cpu_reset     out  CPU reset, active-high
//   seq_done      out  high while running with all resets released
//   rst_cause     out  last cause: 00 POR, 01 button, 10 soft, 11 PLL loss
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned PERIPH_CYCLES   = 16,
  parameter int unsigned MEM_CYCLES      = 16,
  parameter int unsigned CPU_CYCLES      = 64,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_lock,
  input  logic       btn_n,
  input  logic       soft_rst_req,
  output logic       periph_reset,
  output logic       mem_reset,
  output logic       cpu_reset,
  output logic       seq_done,
  output logic [1:0] rst_cause
);

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_BTN  = 2'b01;
  localparam logic [1:0] CAUSE_SOFT = 2'b10;
  localparam logic [1:0] CAUSE_PLL  = 2'b11;

  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_CYCLES - 1);
  localparam logic [CNT_W-1:0] MEM_LAST    = CNT_W'(MEM_CYCLES - 1);
  localparam logic [CNT_W-1:0] CPU_LAST    = CNT_W'(CPU_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_POR,
    ST_WAIT_LOCK,
    ST_REL_PERIPH,
    ST_REL_MEM,
    ST_REL_CPU,
    ST_RUN,
    ST_ASSERT
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers. The button chain resets to "released" so that no
  // phantom press is seen while coming out of reset.
  // ---------------------------------------------------------------------------
  logic lock_ff1_q, lock_ff2_q;
  logic btn_ff1_q, btn_ff2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_ff1_q <= 1'b0;
      lock_ff2_q <= 1'b0;
      btn_ff1_q  <= 1'b1;
      btn_ff2_q  <= 1'b1;
    end else begin
      lock_ff1_q <= pll_lock;
      lock_ff2_q <= lock_ff1_q;
      btn_ff1_q  <= btn_n;
      btn_ff2_q  <= btn_ff1_q;
    end
  end

  logic lock_s;
  assign lock_s = lock_ff2_q;

  // ---------------------------------------------------------------------------
  // Debouncer: the accepted level follows the synchronised sample only after
  // DEBOUNCE_CYCLES consecutive samples that differ from it; any sample equal
  // to the accepted level restarts the count.
  // ---------------------------------------------------------------------------
  logic             btn_sample;
  logic             btn_pressed_q, btn_pressed_d;
  logic             btn_prev_q;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             btn_rise;

  assign btn_sample = ~btn_ff2_q;

  always_comb begin
    btn_pressed_d = btn_pressed_q;
    db_cnt_d      = db_cnt_q;
    if (btn_sample == btn_pressed_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DEB_LAST) begin
      btn_pressed_d = btn_sample;
      db_cnt_d      = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_pressed_q <= 1'b0;
      btn_prev_q    <= 1'b0;
      db_cnt_q      <= '0;
    end else begin
      btn_pressed_q <= btn_pressed_d;
      btn_prev_q    <= btn_pressed_q;
      db_cnt_q      <= db_cnt_d;
    end
  end

  assign btn_rise = btn_pressed_q & ~btn_prev_q;

  // ---------------------------------------------------------------------------
  // Sequencer FSM: state register
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pend_cause_q, pend_cause_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_POR;
      cnt_q        <= '0;
      pend_cause_q <= CAUSE_POR;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_cause_q <= pend_cause_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM: next state. A trigger always beats a release that would
  // happen on the same clock, so a domain never comes out of reset while a
  // fault is already pending. The cause is captured on entry to ST_ASSERT.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_cause_d = pend_cause_q;
    unique case (state_q)
      ST_POR: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
      ST_WAIT_LOCK: begin
        if (lock_s && !btn_pressed_q) begin
          state_d = ST_REL_PERIPH;
          cnt_d   = '0;
        end
      end
      ST_REL_PERIPH, ST_REL_MEM, ST_REL_CPU: begin
        if (!lock_s) begin
          state_d      = ST_ASSERT;
          pend_cause_d = CAUSE_PLL;
        end else if (btn_pressed_q) begin
          state_d      = ST_ASSERT;
          pend_cause_d = CAUSE_BTN;
        end else if ((state_q == ST_REL_PERIPH) && (cnt_q == PERIPH_LAST)) begin
          state_d = ST_REL_MEM;
          cnt_d   = '0;
        end else if ((state_q == ST_REL_MEM) && (cnt_q == MEM_LAST)) begin
          state_d = ST_REL_CPU;
          cnt_d   = '0;
        end else if ((state_q == ST_REL_CPU) && (cnt_q == CPU_LAST)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d      = ST_ASSERT;
          pend_cause_d = CAUSE_PLL;
        end else if (btn_rise) begin
          state_d      = ST_ASSERT;
          pend_cause_d = CAUSE_BTN;
        end else if (soft_rst_req) begin
          state_d      = ST_ASSERT;
          pend_cause_d = CAUSE_SOFT;
        end
      end
      ST_ASSERT: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_POR;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM: output next-values (registered below)
  // ---------------------------------------------------------------------------
  logic       periph_q, periph_d;
  logic       mem_q, mem_d;
  logic       cpu_q, cpu_d;
  logic       done_q, done_d;
  logic [1:0] cause_q, cause_d;

  always_comb begin
    periph_d = periph_q;
    mem_d    = mem_q;
    cpu_d    = cpu_q;
    done_d   = done_q;
    cause_d  = cause_q;
    unique case (state_q)
      ST_POR, ST_WAIT_LOCK: begin
        periph_d = 1'b1;
        mem_d    = 1'b1;
        cpu_d    = 1'b1;
        done_d   = 1'b0;
      end
      ST_REL_PERIPH: if (state_d == ST_REL_MEM) periph_d = 1'b0;
      ST_REL_MEM:    if (state_d == ST_REL_CPU) mem_d = 1'b0;
      ST_REL_CPU: begin
        if (state_d == ST_RUN) begin
          cpu_d  = 1'b0;
          done_d = 1'b1;
        end
      end
      ST_RUN: ;
      ST_ASSERT: begin
        periph_d = 1'b1;
        mem_d    = 1'b1;
        cpu_d    = 1'b1;
        done_d   = 1'b0;
        cause_d  = pend_cause_q;
      end
      default: begin
        periph_d = 1'b1;
        mem_d    = 1'b1;
        cpu_d    = 1'b1;
        done_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      periph_q <= 1'b1;
      mem_q    <= 1'b1;
      cpu_q    <= 1'b1;
      done_q   <= 1'b0;
      cause_q  <= CAUSE_POR;
    end else begin
      periph_q <= periph_d;
      mem_q    <= mem_d;
      cpu_q    <= cpu_d;
      done_q   <= done_d;
      cause_q  <= cause_d;
    end
  end

  assign periph_reset = periph_q;
  assign mem_reset    = mem_q;
  assign cpu_reset    = cpu_q;
  assign seq_done     = done_q;
  assign rst_cause    = cause_q;

endmodule
